// File: rtl/keymap_port_arbiter.sv
`default_nettype none
// ============================================================================
// keymap_port_arbiter : sole owner of the single-port keymap RAM, shared between
// the scancode translator (4-byte bursts) and the CPU keymap I/O port.
// Optional feature macro: KEYMAP_WRPROT_EN (CPU write protect).
// Revision: 1.0
// ============================================================================
module keymap_port_arbiter #(
    parameter int AW     = 14,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kb_req,
    input  logic [AW-3:0]     kb_key,
    output logic              kb_valid,
    output logic [4*DW-1:0]   kb_data,
    output logic              kb_drop,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_rewind,
    input  logic [DW-1:0]     cpu_din,
    output logic [DW-1:0]     cpu_dout,
    output logic              cpu_ack,
    input  logic              cpu_wp,
    output logic              cpu_wp_err,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_we,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_KB_ISSUE = 3'd1;
    localparam logic [2:0] ST_KB_DRAIN = 3'd2;
    localparam logic [2:0] ST_KB_DONE  = 3'd3;
    localparam logic [2:0] ST_CPU_RD   = 3'd4;
    localparam logic [2:0] ST_CPU_WAIT = 3'd5;
    localparam logic [2:0] ST_CPU_WR   = 3'd6;
    localparam logic [2:0] ST_CPU_HOLD = 3'd7;

    localparam logic       GR_KB     = 1'b0;
    localparam logic       GR_CPU    = 1'b1;
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    logic [2:0]                  state_q,      state_d;
    logic [AW-1:0]               cpu_addr_q,   cpu_addr_d;
    logic [AW-3:0]               key_q,        key_d;
    logic                        kb_pend_q,    kb_pend_d;
    logic                        last_grant_q, last_grant_d;
    logic [1:0]                  beat_q,       beat_d;
    logic [1:0]                  wait_q,       wait_d;
    logic [4*DW-1:0]             kb_data_q,    kb_data_d;
    logic [DW-1:0]               cpu_dout_q,   cpu_dout_d;
    logic                        kb_drop_q,    kb_drop_d;
    logic [RD_LAT-1:0]           tag_vld_q,    tag_vld_d;
    logic [RD_LAT-1:0][1:0]      tag_lane_q,   tag_lane_d;

    logic cpu_req;
    logic kb_active;
    logic kb_accept;
    logic kb_want;
    logic wp_block;

    assign cpu_req   = cpu_rd | cpu_wr;
    assign kb_active = (state_q == ST_KB_ISSUE) || (state_q == ST_KB_DRAIN);
    assign kb_accept = kb_req && !kb_pend_q && !kb_active;
    assign kb_want   = kb_pend_q | kb_accept;

    always_comb begin
        state_d      = state_q;
        cpu_addr_d   = cpu_addr_q;
        key_d        = key_q;
        kb_pend_d    = kb_pend_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        wait_d       = wait_q;
        kb_data_d    = kb_data_q;
        cpu_dout_d   = cpu_dout_q;
        kb_drop_d    = kb_req && !kb_accept;

        if (kb_accept) begin
            key_d     = kb_key;
            kb_pend_d = 1'b1;
        end

        // Each issued beat carries its byte lane down a RD_LAT-deep tag pipe,
        // so the lane is known when its data comes back from the RAM.
        tag_vld_d[0]  = (state_q == ST_KB_ISSUE);
        tag_lane_d[0] = beat_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_lane_d[i] = tag_lane_q[i-1];
        end

        if (tag_vld_q[RD_LAT-1]) begin
            case (tag_lane_q[RD_LAT-1])
                2'd0:    kb_data_d[4*DW-1 -: DW] = ram_dout;
                2'd1:    kb_data_d[3*DW-1 -: DW] = ram_dout;
                2'd2:    kb_data_d[2*DW-1 -: DW] = ram_dout;
                default: kb_data_d[DW-1:0]       = ram_dout;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (cpu_rewind) begin
                    cpu_addr_d = '0;
                end else if (kb_want && (!cpu_req || last_grant_q == GR_CPU)) begin
                    state_d      = ST_KB_ISSUE;
                    beat_d       = 2'd0;
                    kb_pend_d    = 1'b0;
                    last_grant_d = GR_KB;
                end else if (cpu_req) begin
                    state_d      = cpu_rd ? ST_CPU_RD : ST_CPU_WR;
                    last_grant_d = GR_CPU;
                end
            end
            ST_KB_ISSUE: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = ST_KB_DRAIN;
                end
            end
            ST_KB_DRAIN: begin
                if (tag_vld_q[RD_LAT-1] && tag_lane_q[RD_LAT-1] == 2'd3) begin
                    state_d = ST_KB_DONE;
                end
            end
            ST_KB_DONE: begin
                state_d = ST_IDLE;
            end
            ST_CPU_RD: begin
                wait_d  = 2'd0;
                state_d = ST_CPU_WAIT;
            end
            ST_CPU_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    cpu_dout_d = ram_dout;
                    state_d    = ST_CPU_HOLD;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_CPU_WR: begin
                state_d = ST_CPU_HOLD;
            end
            default: begin
                if (!cpu_req) begin
                    cpu_addr_d = cpu_addr_q + AW'(1);
                    state_d    = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cpu_addr_q   <= '0;
            key_q        <= '0;
            kb_pend_q    <= 1'b0;
            last_grant_q <= GR_CPU;
            beat_q       <= 2'd0;
            wait_q       <= 2'd0;
            kb_data_q    <= '0;
            cpu_dout_q   <= '0;
            kb_drop_q    <= 1'b0;
            tag_vld_q    <= '0;
            tag_lane_q   <= '0;
        end else begin
            state_q      <= state_d;
            cpu_addr_q   <= cpu_addr_d;
            key_q        <= key_d;
            kb_pend_q    <= kb_pend_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            kb_data_q    <= kb_data_d;
            cpu_dout_q   <= cpu_dout_d;
            kb_drop_q    <= kb_drop_d;
            tag_vld_q    <= tag_vld_d;
            tag_lane_q   <= tag_lane_d;
        end
    end

`ifdef KEYMAP_WRPROT_EN
    assign wp_block   = cpu_wp;
    assign cpu_wp_err = (state_q == ST_CPU_WR) && cpu_wp;
`else
    logic unused_wp;
    assign unused_wp  = cpu_wp;
    assign wp_block   = 1'b0;
    assign cpu_wp_err = 1'b0;
`endif

    always_comb begin
        ram_addr = '0;
        case (state_q)
            ST_KB_ISSUE: ram_addr = {key_q, beat_q};
            ST_CPU_RD,
            ST_CPU_WR:   ram_addr = cpu_addr_q;
            default:     ram_addr = '0;
        endcase
    end

    assign ram_we   = (state_q == ST_CPU_WR) && !wp_block;
    assign ram_din  = (state_q == ST_CPU_WR) ? cpu_din : '0;
    assign cpu_ack  = (state_q == ST_CPU_HOLD) && cpu_req;
    assign kb_valid = (state_q == ST_KB_DONE);
    assign kb_data  = kb_data_q;
    assign kb_drop  = kb_drop_q;
    assign cpu_dout = cpu_dout_q;

endmodule
`default_nettype wire
